// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch port, data port and memory-side bus of the unified memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;
  logic                  dm_rd;
  logic                  dm_wr;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ready;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;
  logic                  proto_err;
  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
           busy, proto_err
  );
  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
           busy, proto_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-ported memory between fetch and data ports; define ARB_FAIR_EN for alternating tie-break
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_we;
  logic                r_src;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_proto_err;
  logic                r_mem_en;
  logic                r_mem_we;
  logic                w_dm_req;
  logic                w_pick_dm;
  logic                w_grant;
  logic                w_last_beat;
  assign w_dm_req    = bus.dm_rd | bus.dm_wr;
  assign w_grant     = (r_state == IDLE) & (w_dm_req | bus.if_req);
  assign w_last_beat = (r_state == WAIT) & (r_cnt == CW'(1));
`ifdef ARB_FAIR_EN
  logic r_last_dm;
  assign w_pick_dm = w_dm_req & ~(bus.if_req & r_last_dm);
  // remember which port completed last so a tie goes to the other one
  always_ff @(posedge clk)
    if (!rst) r_last_dm <= 1'b0;
    else if (r_state == RESP) r_last_dm <= r_src;
`else
  assign w_pick_dm = w_dm_req;
`endif
  // state register
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state: grant, single-cycle strobe, latency wait, one-cycle response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? ISSUE : IDLE;
      ISSUE:   w_next = r_we ? RESP : WAIT;
      WAIT:    w_next = (r_cnt == CW'(1)) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // latch the winner, drive registered memory fields, count latency, capture read data
  always_ff @(posedge clk)
    if (!rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_src       <= 1'b0;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_proto_err <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_en <= w_grant;
      r_mem_we <= w_grant & w_pick_dm & bus.dm_wr;
      if (w_grant) begin
        r_addr  <= w_pick_dm ? bus.dm_addr : bus.if_addr;
        r_wdata <= w_pick_dm ? bus.dm_wdata : '0;
        r_be    <= w_pick_dm ? bus.dm_be : '0;
        r_we    <= w_pick_dm & bus.dm_wr;
        r_src   <= w_pick_dm;
        if (w_pick_dm & bus.dm_rd & bus.dm_wr) r_proto_err <= 1'b1;
      end
      if (r_state == ISSUE && !r_we) r_cnt <= CW'(MEM_LAT);
      else if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_last_beat && r_src) r_dm_rdata <= bus.mem_rdata;
      if (w_last_beat && !r_src) r_if_rdata <= bus.mem_rdata;
    end
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_ready  = (r_state == RESP) & ~r_src;
  assign bus.dm_ready  = (r_state == RESP) & r_src;
  assign bus.busy      = r_state != IDLE;
  assign bus.proto_err = r_proto_err;
endmodule
